// File: rtl/soc_mem_arb_pkg.sv
// Shared constants and types for the two-port on-chip RAM arbiter.
package soc_mem_arb_pkg;

    localparam int NUM_PORTS        = 2;
    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_READ_LATENCY = 1;

    typedef logic port_id_t;

endpackage

// File: rtl/soc_mem_arb_rvalid_pipe.sv
// {valid, port_id} delay line that lines read tags up with RAM read data.
module soc_mem_arb_rvalid_pipe
    import soc_mem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_READ_LATENCY
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     in_vld,
    input  port_id_t in_pid,
    output logic     out_vld,
    output port_id_t out_pid
);

    logic     [DEPTH:1] vld_pipe;
    port_id_t [DEPTH:1] pid_pipe;

    // Clearing on reset drops any read still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            pid_pipe <= '0;
        end else begin
            for (int i = DEPTH; i > 1; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pid_pipe[i] <= pid_pipe[i-1];
            end
            vld_pipe[1] <= in_vld;
            pid_pipe[1] <= in_pid;
        end
    end

    assign out_vld = vld_pipe[DEPTH];
    assign out_pid = pid_pipe[DEPTH];

endmodule

// File: rtl/soc_onchip_mem_arbiter.sv
// Round-robin, lockable arbiter sharing one single-port RAM between two
// Avalon-MM requesters; read data is steered back by a tag pipeline.
module soc_onchip_mem_arbiter
    import soc_mem_arb_pkg::*;
#(
    parameter int  ADDR_W       = DEF_ADDR_W,
    parameter int  DATA_W       = 32,
    parameter int  READ_LATENCY = DEF_READ_LATENCY,
    localparam int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    input  logic              s0_lock,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    input  logic              s1_lock,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic [ADDR_W-1:0] m_address,
    output logic [BE_W-1:0]   m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata
);

    logic     req0, req1, last_grant, owner_lock;
    logic     gnt_vld, gnt_rd, rsp_vld;
    port_id_t gnt_pid, rsp_pid;

    assign req0       = s0_read | s0_write;
    assign req1       = s1_read | s1_write;
    assign owner_lock = last_grant ? s1_lock : s0_lock;

    // Under contention the previous owner keeps the slot only while locked.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_pid = 1'b0;
        if (reset_n && !freeze) begin
            if (req0 && req1) begin
                gnt_vld = 1'b1;
                gnt_pid = owner_lock ? last_grant : ~last_grant;
            end else if (req0 || req1) begin
                gnt_vld = 1'b1;
                gnt_pid = req1;
            end
        end
    end

    assign gnt_rd = gnt_vld & (gnt_pid ? s1_read : s0_read);

    always_comb begin
        m_chipselect = gnt_vld;
        m_address    = gnt_pid ? s1_address   : s0_address;
        m_writedata  = gnt_pid ? s1_writedata : s0_writedata;
        m_write      = gnt_vld & (gnt_pid ? s1_write : s0_write);
        m_byteenable = gnt_rd ? '1 : (gnt_pid ? s1_byteenable : s0_byteenable);
    end

    // Idle ports see waitrequest low; everything stalls while in reset.
    assign s0_waitrequest = ~reset_n | (req0 & ~(gnt_vld & (gnt_pid == 1'b0)));
    assign s1_waitrequest = ~reset_n | (req1 & ~(gnt_vld & (gnt_pid == 1'b1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            m_clken    <= 1'b0;
        end else begin
            m_clken <= 1'b1;
            if (gnt_vld) last_grant <= gnt_pid;
        end
    end

    soc_mem_arb_rvalid_pipe #(.DEPTH(READ_LATENCY)) u_rvalid_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (gnt_rd),
        .in_pid  (gnt_pid),
        .out_vld (rsp_vld),
        .out_pid (rsp_pid)
    );

    assign s0_readdatavalid = rsp_vld & (rsp_pid == 1'b0);
    assign s1_readdatavalid = rsp_vld & (rsp_pid == 1'b1);
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;

endmodule

// File: tb/tb_soc_onchip_mem_arbiter.sv
// Drives a latency-1 and a latency-2 arbiter (each with its own RAM) from the
// same stimulus and compares both against a transaction-level model.
module tb_soc_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n, freeze;
    logic [9:0]  s0_address, s1_address;
    logic [3:0]  s0_byteenable, s1_byteenable;
    logic        s0_read, s0_write, s1_read, s1_write, s0_lock, s1_lock;
    logic [31:0] s0_writedata, s1_writedata;

    logic [1:0]       w0, w1, v0, v1, mcs, mwe, mce;
    logic [1:0][31:0] rd0, rd1, mwd, mrd;
    logic [1:0][9:0]  madr;
    logic [1:0][3:0]  mbe;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] mem [1024];
        logic [31:0] q1, q2;

        soc_onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(g + 1)) dut (
            .clk(clk), .reset_n(reset_n), .freeze(freeze),
            .s0_address(s0_address), .s0_byteenable(s0_byteenable),
            .s0_read(s0_read), .s0_write(s0_write), .s0_writedata(s0_writedata),
            .s0_lock(s0_lock), .s0_waitrequest(w0[g]), .s0_readdata(rd0[g]),
            .s0_readdatavalid(v0[g]),
            .s1_address(s1_address), .s1_byteenable(s1_byteenable),
            .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
            .s1_lock(s1_lock), .s1_waitrequest(w1[g]), .s1_readdata(rd1[g]),
            .s1_readdatavalid(v1[g]),
            .m_address(madr[g]), .m_byteenable(mbe[g]), .m_chipselect(mcs[g]),
            .m_write(mwe[g]), .m_writedata(mwd[g]), .m_clken(mce[g]),
            .m_readdata(mrd[g])
        );

        // RAM: q1 is the unregistered-output data, q2 adds the output register.
        initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        always @(posedge clk) begin
            if (mce[g] && mcs[g]) begin
                if (mwe[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe[g][b]) mem[madr[g]][8*b +: 8] = mwd[g][8*b +: 8];
                end else begin
                    q1 <= mem[madr[g]];
                end
            end
            q2 <= q1;
        end
        assign mrd[g] = (g == 0) ? q1 : q2;
    end

    // ---------------- reference model ----------------
    typedef struct { int acc; logic port; logic [31:0] data; } rsp_t;

    int          checks = 0, errors = 0, cyc = 0;
    logic        mlast = 1'b1, clk_on = 1'b0;
    logic        eg_v, eg_p, stall0, stall1;
    logic [31:0] shadow [1024];
    rsp_t        pend [$];
    int          rcnt [2][2];

    initial for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;

    task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat%0d: got %h expected %h", tag, g + 1, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input int g, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat%0d: got %b expected %b", tag, g + 1, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        for (int g = 0; g < 2; g++) begin
            rcnt[g][0] = 0;
            rcnt[g][1] = 0;
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick();
        logic        r0, r1, ev0, ev1, pw;
        logic [31:0] ed0, ed1, pd;
        logic [9:0]  pa;
        logic [3:0]  pbe;
        #1;
        if (!reset_n) begin
            pend.delete();
            mlast  = 1'b1;
            clk_on = 1'b0;
        end
        r0   = s0_read | s0_write;
        r1   = s1_read | s1_write;
        eg_v = 1'b0;
        eg_p = 1'b0;
        if (reset_n && !freeze && (r0 || r1)) begin
            eg_v = 1'b1;
            if (r0 && r1) eg_p = (mlast ? s1_lock : s0_lock) ? mlast : ~mlast;
            else          eg_p = r1;
        end
        stall0 = r0 && !(eg_v && !eg_p);
        stall1 = r1 && !(eg_v && eg_p);
        pa  = eg_p ? s1_address   : s0_address;
        pw  = eg_p ? s1_write     : s0_write;
        pd  = eg_p ? s1_writedata : s0_writedata;
        pbe = eg_p ? s1_byteenable : s0_byteenable;

        for (int g = 0; g < 2; g++) begin
            ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
            foreach (pend[k]) begin
                if (pend[k].acc + g == cyc) begin
                    if (pend[k].port) begin ev1 = 1'b1; ed1 = pend[k].data; end
                    else              begin ev0 = 1'b1; ed0 = pend[k].data; end
                end
            end
            chkb("s0_waitrequest", g, w0[g], !reset_n || stall0);
            chkb("s1_waitrequest", g, w1[g], !reset_n || stall1);
            chkb("m_chipselect", g, mcs[g], eg_v);
            chkb("m_clken", g, mce[g], clk_on);
            if (eg_v) begin
                chk("m_address", g, 32'(madr[g]), 32'(pa));
                chkb("m_write", g, mwe[g], pw);
                if (pw) begin
                    chk("m_writedata", g, mwd[g], pd);
                    chk("m_byteenable", g, 32'(mbe[g]), 32'(pbe));
                end else begin
                    chk("m_byteenable_rd", g, 32'(mbe[g]), 32'hF);
                end
            end else begin
                chkb("m_write_idle", g, mwe[g], 1'b0);
            end
            chkb("s0_readdatavalid", g, v0[g], ev0);
            chkb("s1_readdatavalid", g, v1[g], ev1);
            if (ev0) chk("s0_readdata", g, rd0[g], ed0);
            if (ev1) chk("s1_readdata", g, rd1[g], ed1);
            if (v0[g]) rcnt[g][0]++;
            if (v1[g]) rcnt[g][1]++;
        end

        @(posedge clk);
        if (reset_n) begin
            cyc++;
            if (eg_v) begin
                mlast = eg_p;
                if (pw) begin
                    for (int b = 0; b < 4; b++)
                        if (pbe[b]) shadow[pa][8*b +: 8] = pd[8*b +: 8];
                end else begin
                    pend.push_back('{cyc, eg_p, shadow[pa]});
                end
            end
            clk_on = 1'b1;
            while (pend.size() > 0 && pend[0].acc + 1 < cyc) void'(pend.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic lk);
        s0_read = rd; s0_write = wr; s0_address = a;
        s0_writedata = d; s0_byteenable = be; s0_lock = lk;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic lk);
        s1_read = rd; s1_write = wr; s1_address = a;
        s1_writedata = d; s1_byteenable = be; s1_lock = lk;
    endtask

    task automatic rand_port(input int p);
        int          op;
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        lk;
        op = int'($urandom_range(0, 3));
        a  = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
        d  = $urandom;
        be = 4'($urandom_range(1, 15));
        lk = ($urandom_range(0, 3) == 0);
        if (p == 0) drv0(op == 1 || op == 3, op == 2, a, d, be, lk);
        else        drv1(op == 1 || op == 3, op == 2, a, d, be, lk);
    endtask

    initial begin
        reset_n = 1'b0;
        freeze  = 1'b0;
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // write then read back on port 0
        clr_cnt();
        drv0(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b0); tick();
        drv0(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b0);        tick();
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);          tick(); tick();
        for (int g = 0; g < 2; g++) begin
            chk("wr_rd s0 pulses", g, 32'(rcnt[g][0]), 32'd1);
            chk("wr_rd s1 pulses", g, 32'(rcnt[g][1]), 32'd0);
        end

        // preload distinct words, then unlocked contention
        drv0(1'b0, 1'b1, 10'h010, 32'h1111_0010, 4'hF, 1'b0); tick();
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        drv1(1'b0, 1'b1, 10'h020, 32'h2222_0020, 4'hF, 1'b0); tick();
        clr_cnt();
        drv0(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0);
        drv1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0);
        repeat (8) tick();
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        tick(); tick();
        for (int g = 0; g < 2; g++) begin
            chk("alternate s0 pulses", g, 32'(rcnt[g][0]), 32'd4);
            chk("alternate s1 pulses", g, 32'(rcnt[g][1]), 32'd4);
        end

        // s1 last owned the slot; with lock it keeps it until it lets go
        clr_cnt();
        drv0(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0);
        drv1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b1);
        repeat (6) tick();
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        tick();
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        tick(); tick();
        for (int g = 0; g < 2; g++) begin
            chk("lock s0 pulses", g, 32'(rcnt[g][0]), 32'd1);
            chk("lock s1 pulses", g, 32'(rcnt[g][1]), 32'd6);
        end

        // freeze right after a granted read
        drv0(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b0); tick();
        freeze = 1'b1;
        drv0(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0);
        drv1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0);
        repeat (3) tick();
        freeze = 1'b0;
        tick(); tick();
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        tick(); tick();

        // reset while a read is in flight
        clr_cnt();
        drv0(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b0); tick();
        reset_n = 1'b0;
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        tick();
        reset_n = 1'b1;
        tick(); tick();
        for (int g = 0; g < 2; g++)
            chk("dropped read pulses", g, 32'(rcnt[g][0]), 32'd0);
        drv0(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0);
        drv1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0);
        #1;
        chkb("post-reset contention s0 wait", 0, w0[0], 1'b0);
        chkb("post-reset contention s1 wait", 0, w1[0], 1'b1);
        tick(); tick();
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        tick(); tick();

        // top-of-memory word, full then partial byte write
        drv0(1'b0, 1'b1, 10'h3FF, 32'hA5A5_5A5A, 4'hF, 1'b0); tick();
        drv0(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0, 1'b0);         tick();
        drv0(1'b0, 1'b1, 10'h3FF, 32'h0000_0000, 4'h5, 1'b0); tick();
        drv0(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0, 1'b0);         tick();
        drv0(1'b1, 1'b0, 10'h000, 32'h0, 4'h0, 1'b0);         tick();
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        tick(); tick();

        // random traffic; a stalled port holds its request
        for (int n = 0; n < 400; n++) begin
            freeze = ($urandom_range(0, 7) == 0);
            if (!stall0) rand_port(0);
            if (!stall1) rand_port(1);
            tick();
        end
        freeze = 1'b0;
        drv0(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        drv1(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
